onehot_rr_arbiter: RTL and testbench
====================================

// Module: onehot_rr_arbiter
// PURPOSE
//  Round-robin arbiter for up to 8 requesters. Holds one grant at a time and
//  presents it as a registered one-hot vector with a valid flag.
//  Sits directly upstream of the 8-to-3 one-hot encoder: grant drives the
//  encoder's din and grant_valid drives its en, so dout is the owner index.
//  Guarantees the encoder only ever sees all-zero or exactly-one-hot input.
// PARAMETERS
//  N         8   number of requesters; must be 8 to match the encoder width
//  MAX_HOLD  16  max cycles a grant is held before forced release (>=2)
//  CW        5   hold counter width, >= clog2(MAX_HOLD)+1
// PORTS
//  clk          in   1  single clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  req          in   N  request vector, bit i = requester i, level-sensitive
//  done         in   1  owner finished; single-cycle pulse, ignored in IDLE
//  grant        out  N  registered one-hot grant, 0 when idle (encoder din)
//  grant_valid  out  1  registered, 1 iff grant != 0 (encoder en)
//  timeout      out  1  one-cycle pulse on forced release by MAX_HOLD
// BEHAVIOUR
//  Reset (async assert, sync release): grant=0, grant_valid=0, timeout=0,
//   state=IDLE, hold_cnt=0, last_ptr=N-1, so bit 0 has first priority.
//  FSM states: IDLE, BUSY.
//  IDLE: if req!=0, pick the first set bit scanning from (last_ptr+1) mod N
//   upward, wrapping at N-1->0. Next edge: grant=onehot(pick),
//   grant_valid=1, hold_cnt=0, go BUSY. Latency req->grant = 1 cycle.
//   If req==0, stay in IDLE with outputs 0.
//  BUSY: hold_cnt increments each cycle. Release condition, highest first:
//   (a) done=1; (b) req[owner]=0; (c) hold_cnt==MAX_HOLD-1.
//   On release, next edge: grant=0, grant_valid=0, last_ptr=owner, go IDLE.
//   timeout=1 for that one cycle only when (c) fires and (a),(b) are false.
//  Gap rule: at least one idle cycle (grant=0) between successive grants,
//   including re-grants to the same requester. Max throughput is 1 grant
//   per 2 cycles.
//  Changes in req while BUSY never move the grant. Non-owner requests wait.
//  A requester that loses by timeout gets lowest priority on the next pick
//   through the last_ptr update. No starvation: every continuously asserted
//   request is granted within N*(MAX_HOLD+1) cycles.
//  rst_n low mid-grant clears grant and grant_valid immediately; last_ptr
//   returns to N-1.
//  Invariant (assert): $onehot0(grant) && (grant_valid == |grant).
// STRUCTURE
//  Shared package: N_REQ=8 and state enum {IDLE, BUSY}. MAX_HOLD stays a
//   module parameter.
//  Sub-module rr_pick: combinational. Inputs req and last_ptr; outputs a
//   one-hot pick and its index. Implement as rotate, then fixed priority,
//   then rotate back.
//  Top module holds the FSM, hold_cnt, last_ptr and the output registers.
// TESTING
//  1 Hold rst_n=0 with req=8'hFF -> grant=0, grant_valid=0, timeout=0.
//  2 After reset, req=8'b0000_0101 -> next edge grant=8'b0000_0001. Pulse
//    done -> grant=0 for 1 cycle, then grant=8'b0000_0100.
//  3 Wrap: after bit 7 served, req=8'b1000_0001 -> grant=8'b0000_0001, not
//    bit 7.
//  4 Timeout with MAX_HOLD=16: req=8'b0000_1000 held, done=0 -> grant held
//    16 cycles, then grant=0 with timeout=1 for 1 cycle, then re-grant of
//    8'b0000_1000.
//  5 Owner drops req while BUSY (other reqs pending) -> grant=0 next edge,
//    timeout=0. Same-cycle done and hold_cnt==MAX_HOLD-1 -> timeout=0.
//  6 rst_n pulsed low mid-grant -> grant=0 immediately (no clock edge), then
//    req=8'hFF -> grant=8'b0000_0001. Feed grant/grant_valid into the encoder
//    and check dout==owner index every cycle.

Source files
------------

// File: rtl/onehot_rr_arbiter_pkg.sv
// rtl/onehot_rr_arbiter_pkg.sv - shared requester count, pointer width and FSM state type
package onehot_rr_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// rtl/onehot_rr_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface onehot_rr_arbiter_if;
  import onehot_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_valid, timeout
  );

endinterface

// File: rtl/onehot_rr_arbiter_rr_pick.sv
// rtl/onehot_rr_arbiter_rr_pick.sv - combinational round-robin pick starting after last_ptr
module rr_pick
  import onehot_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [PTR_W-1:0] pick_idx,
  output logic             pick_valid
);

  logic [PTR_W-1:0]   start;
  logic [2*N_REQ-1:0] req2;
  logic [N_REQ-1:0]   rot;
  logic [PTR_W-1:0]   rot_idx;

  // N_REQ is a power of two, so pointer arithmetic wraps modulo N_REQ for free
  assign start = last_ptr + PTR_W'(1);
  assign req2  = {req, req};
  assign rot   = N_REQ'(req2 >> start);

  always_comb begin
    rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = PTR_W'(i);
    end
  end

  assign pick_idx   = rot_idx + start;
  assign pick_valid = |req;
  assign pick       = pick_valid ? (N_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/onehot_rr_arbiter.sv
// rtl/onehot_rr_arbiter.sv - round-robin arbiter with registered one-hot grant and hold timeout
module onehot_rr_arbiter
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N        = N_REQ,
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  onehot_rr_arbiter_if.slave  bus
);

  state_t           state, state_nxt;
  logic [CW-1:0]    hold_cnt, hold_nxt;
  logic [PTR_W-1:0] last_ptr, last_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;
  logic [N-1:0]     grant_q, grant_nxt;
  logic             grant_valid_q, grant_valid_nxt;
  logic             timeout_q, timeout_nxt;

  logic [N-1:0]     pick;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic             rel_done, rel_drop, rel_hold, rel_any;

  rr_pick u_pick (
    .req        (bus.req),
    .last_ptr   (last_ptr),
    .pick       (pick),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  assign rel_done = bus.done;
  assign rel_drop = !bus.req[owner];
  assign rel_hold = (hold_cnt == CW'(MAX_HOLD - 1));
  assign rel_any  = rel_done || rel_drop || rel_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      last_ptr      <= PTR_W'(N - 1);
      owner         <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_nxt;
      last_ptr      <= last_nxt;
      owner         <= owner_nxt;
      grant_q       <= grant_nxt;
      grant_valid_q <= grant_valid_nxt;
      timeout_q     <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = BUSY;
      BUSY:    if (rel_any)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Release always passes through IDLE, which enforces the one-cycle gap between grants
  always_comb begin
    hold_nxt    = hold_cnt;
    last_nxt    = last_ptr;
    owner_nxt   = owner;
    grant_nxt   = '0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_nxt = pick;
          owner_nxt = pick_idx;
          hold_nxt  = '0;
        end
      end
      BUSY: begin
        if (rel_any) begin
          last_nxt    = owner;
          timeout_nxt = rel_hold && !rel_done && !rel_drop;
        end else begin
          grant_nxt = grant_q;
          hold_nxt  = hold_cnt + CW'(1);
        end
      end
      default: ;
    endcase
    grant_valid_nxt = |grant_nxt;
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.grant) && (bus.grant_valid == |bus.grant));

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb/tb_onehot_rr_arbiter.sv - scoreboard bench for onehot_rr_arbiter with encoder check
module tb_onehot_rr_arbiter;
  import onehot_rr_arbiter_pkg::*;

  localparam int MAX_HOLD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  onehot_rr_arbiter_if bus ();

  onehot_rr_arbiter #(.N(N_REQ), .MAX_HOLD(MAX_HOLD), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] grant;
    logic       valid;
    logic       to;
    int         idx;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  logic       m_busy;
  int         m_cnt;
  int         m_last;
  int         m_owner;
  logic [7:0] m_grant;
  logic       m_to;

  function automatic logic [2:0] enc(input logic [7:0] din, input logic en);
    logic [2:0] d;
    d = 3'd0;
    if (en) for (int i = 0; i < 8; i++) if (din[i]) d = 3'(i);
    return d;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_cnt = 0; m_last = 7; m_owner = 0; m_grant = 8'h00; m_to = 1'b0;
  endtask

  // Advance the reference model by one edge using the inputs currently driven
  task automatic model_clock();
    exp_t e;
    m_to = 1'b0;
    if (!m_busy) begin
      if (bus.req != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          if (bus.req[(m_last + k) % 8]) begin
            m_owner = (m_last + k) % 8;
            break;
          end
        end
        m_grant = 8'h01 << m_owner;
        m_busy  = 1'b1;
        m_cnt   = 0;
      end
    end else if (bus.done || !bus.req[m_owner] || m_cnt == MAX_HOLD - 1) begin
      m_to    = !bus.done && bus.req[m_owner];
      m_grant = 8'h00;
      m_last  = m_owner;
      m_busy  = 1'b0;
    end else begin
      m_cnt++;
    end
    e.grant = m_grant; e.valid = (m_grant != 8'h00); e.to = m_to; e.idx = m_owner;
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_clock();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    if (bus.grant !== e.grant) begin
      miscompares++;
      $display("FAIL grant: got %h expected %h at %0t", bus.grant, e.grant, $time);
    end
    vectors++;
    if (bus.grant_valid !== e.valid) begin
      miscompares++;
      $display("FAIL grant_valid: got %b expected %b at %0t", bus.grant_valid, e.valid, $time);
    end
    vectors++;
    if (bus.timeout !== e.to) begin
      miscompares++;
      $display("FAIL timeout: got %b expected %b at %0t", bus.timeout, e.to, $time);
    end
    if (e.valid) begin
      vectors++;
      if (enc(bus.grant, bus.grant_valid) !== 3'(e.idx)) begin
        miscompares++;
        $display("FAIL encoder_dout: got %0d expected %0d at %0t",
                 enc(bus.grant, bus.grant_valid), e.idx, $time);
      end
    end
  endtask

  task automatic expect_grant(input string name, input logic [7:0] g, input logic to);
    vectors++;
    if (bus.grant !== g || bus.timeout !== to) begin
      miscompares++;
      $display("FAIL %s: got grant=%h timeout=%b expected grant=%h timeout=%b",
               name, bus.grant, bus.timeout, g, to);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.req = 8'hFF; bus.done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    expect_grant("reset_grant", 8'h00, 1'b0);
    vectors++;
    if (bus.grant_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b expected 0", bus.grant_valid);
    end
    @(negedge clk);
    bus.req = 8'h00;
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    bus.req = 8'b0000_0101;
    cycle(); expect_grant("basic_first", 8'h01, 1'b0);
    bus.done = 1'b1;
    cycle(); expect_grant("basic_gap", 8'h00, 1'b0);
    bus.done = 1'b0;
    cycle(); expect_grant("basic_second", 8'h04, 1'b0);
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0; bus.req = 8'h00;
    cycle();
  endtask

  task automatic test_wrap();
    bus.req = 8'h80;
    cycle(); expect_grant("wrap_bit7", 8'h80, 1'b0);
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0; bus.req = 8'b1000_0001;
    cycle(); expect_grant("wrap_bit0", 8'h01, 1'b0);
    bus.req = 8'h00;
    cycle();
    cycle();
  endtask

  task automatic test_timeout();
    bus.req = 8'b0000_1000;
    cycle(); expect_grant("to_grant", 8'h08, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      cycle(); expect_grant("to_hold", 8'h08, 1'b0);
    end
    cycle(); expect_grant("to_release", 8'h00, 1'b1);
    cycle(); expect_grant("to_regrant", 8'h08, 1'b0);
    bus.req = 8'h00;
    cycle();
    cycle();
  endtask

  task automatic test_drop_and_done();
    bus.req = 8'b0001_0010;
    cycle(); expect_grant("drop_owner", 8'h10, 1'b0);
    bus.req = 8'b0000_0010;
    cycle(); expect_grant("drop_release", 8'h00, 1'b0);
    cycle(); expect_grant("drop_next", 8'h02, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) cycle();
    bus.done = 1'b1;
    cycle(); expect_grant("done_at_limit", 8'h00, 1'b0);
    bus.done = 1'b0; bus.req = 8'h00;
    cycle();
  endtask

  task automatic test_midreset();
    bus.req = 8'hFF;
    cycle();
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    expect_grant("midreset_async", 8'h00, 1'b0);
    vectors++;
    if (bus.grant_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_valid: got %b expected 0", bus.grant_valid);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(); expect_grant("midreset_regrant", 8'h01, 1'b0);
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    cycle(); expect_grant("midreset_next", 8'h02, 1'b0);
    bus.req = 8'h00;
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      bus.req  = 8'($urandom_range(0, 255));
      bus.done = ($urandom_range(0, 5) == 0);
      cycle();
    end
    bus.req = 8'h00; bus.done = 1'b0;
    cycle();
  endtask

  initial begin
    bus.req = 8'h00; bus.done = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_drop_and_done();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
